serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 138 +++++++++++++
 tb/tb_serial_subtractor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// serial_subtractor: bit-serial, LSB-first diff = a - b - borrow_in using one full-subtract cell.
// Optional signed-overflow output `ovf` is present when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] part_next;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             accept;
  logic             last_bit;
  logic             d_bit;
  logic             bo_bit;

  assign accept   = (state == S_IDLE) && start;
  assign last_bit = (state == S_SHIFT) && (cnt == LAST_BIT);

  // Full-subtract cell on the current LSBs and the registered borrow.
  assign d_bit     = a_sr[0] ^ b_sr[0] ^ br;
  assign bo_bit    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign part_next = {d_bit, part[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_SHIFT;
      S_SHIFT: if (cnt == LAST_BIT) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      part <= '0;
      cnt  <= '0;
      br   <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      part <= '0;
      cnt  <= '0;
      br   <= borrow_in;
    end else if (state == S_SHIFT) begin
      a_sr <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      part <= part_next;
      cnt  <= cnt + CNT_W'(1);
      br   <= bo_bit;
    end
  end

  // Visible results only move on the edge that retires the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (last_bit) begin
      diff       <= part_next;
      borrow_out <= bo_bit;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      if (last_bit) begin
        ovf <= (a_msb != b_msb) && (part_next[WIDTH-1] != a_msb);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// tb_serial_subtractor: directed + random checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         borrow_in = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic         borrow_out;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, borrow, diff} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbin);
    int unsigned  av;
    int unsigned  sv;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    av = ma;
    sv = mb + mbin;
    d  = W'(av - sv);
    bo = (av < sv);
    ov = (ma[W-1] != mb[W-1]) && (d[W-1] != ma[W-1]);
    return {ov, bo, d};
  endfunction

  task automatic check_result(input string tag, input logic [W+1:0] exp);
    check({tag, "_diff"}, 32'(diff), 32'(exp[W-1:0]));
    check({tag, "_borrow"}, 32'(borrow_out), 32'(exp[W]));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(exp[W+1]));
`endif
  endtask

  // One transaction from IDLE; returns with the DUT back in IDLE.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        input string tag);
    logic [W+1:0] exp;
    logic [W-1:0] prev_diff;
    int           lat;
    exp = model(ta, tb_v, tbin);
    @(negedge clk);
    a = ta; b = tb_v; borrow_in = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prev_diff = diff;
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 4 * W) begin
      @(posedge clk); #1;
      lat++;
      if (busy) check({tag, "_stable"}, 32'(diff), 32'(prev_diff));
      if (busy && done) check({tag, "_busydone"}, 32'd1, 32'd0);
    end
    check({tag, "_latency"}, 32'(lat), 32'(W));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check_result(tag, exp);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [W+1:0] exp;
    logic [W-1:0] qa, qb, hold_diff;
    logic         qbin;

    // Reset state
    @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(8'h05, 8'h03, 1'b0, "d05_03");
    run_op(8'h03, 8'h05, 1'b0, "d03_05");
    run_op(8'h00, 8'h00, 1'b1, "d00_00_b");
    run_op(8'h80, 8'h01, 1'b0, "d80_01");
    run_op(8'h10, 8'h01, 1'b0, "d10_01");
    run_op(8'hFF, 8'hFF, 1'b1, "dFF_FF_b");
    run_op(8'h7F, 8'h80, 1'b0, "d7F_80");

    // Random operands
    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), "rand");
    end

    // start held high: accepts only in IDLE, one result per W+2 cycles
    qa = '0; qb = '0; qbin = 1'b0; hold_diff = diff;
    for (int k = 0; k < 4 * (W + 2); k++) begin
      @(negedge clk);
      start = 1'b1;
      a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom_range(0, 1));
      if (k % (W + 2) == 0) begin
        qa = a; qb = b; qbin = borrow_in; hold_diff = diff;
      end
      @(posedge clk); #1;
      if (k % (W + 2) == W) begin
        check("hold_done", 32'(done), 32'd1);
        exp = model(qa, qb, qbin);
        check_result("hold", exp);
      end else begin
        check("hold_nodone", 32'(done), 32'd0);
        if (k % (W + 2) < W) check("hold_stable", 32'(diff), 32'(hold_diff));
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;

    // Reset during SHIFT aborts and clears results
    run_op(8'h05, 8'h03, 1'b0, "pre_rst");
    @(negedge clk);
    a = 8'h12; b = 8'h34; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("abort_nodone", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < W + 2; k++) begin
      @(posedge clk); #1;
      check("post_rst_nodone", 32'(done), 32'd0);
    end
    run_op(8'hAA, 8'h55, 1'b0, "dAA_55");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
